// File: rtl/pwm_dac.sv
// pwm_dac: converts offset-binary samples into a registered single-bit PWM stream for an RC-filter DAC
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   enable           run the PWM; low freezes counters and forces pwm_out low
//   sample_in        offset-binary sample, midpoint 2^(WIDTH-1)
//   sample_valid     sample_in valid this cycle
//   sample_ready     holding register empty
//   gain             attenuation shift around the midpoint, sampled when a period loads
//   clr_underrun     synchronous clear of the sticky underrun flag
//   pwm_out          registered PWM output
//   period_tick      one-cycle pulse on the cycle a new duty takes effect
//   underrun         sticky: a period started with no fresh sample
module pwm_dac #(
    parameter int PRESCALE = 1,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [1:0]       gain,
    input  logic             clr_underrun,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             underrun
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic signed [WIDTH:0] MID = {2'b01, {(WIDTH-1){1'b0}}};

    logic [PW-1:0]           pre;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        duty;
    logic [WIDTH-1:0]        hold;
    logic                    hold_full;
    logic                    step;
    logic                    wrap;
    logic                    accept;
    logic signed [WIDTH:0]   d;
    logic signed [WIDTH:0]   ds;
    logic signed [WIDTH:0]   sum;

    // Attenuation is an arithmetic shift of the midpoint-relative value, so the
    // result always stays inside 0..2^WIDTH-1 without saturation.
    always_comb begin
        step   = enable & (pre == PW'(PRESCALE - 1));
        wrap   = step & (&cnt);
        accept = sample_valid & ~hold_full;
        d      = $signed({1'b0, hold}) - MID;
        ds     = d >>> gain;
        sum    = ds + MID;
    end

    assign sample_ready = ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre         <= '0;
            cnt         <= '0;
            duty        <= MID[WIDTH-1:0];
            hold        <= '0;
            hold_full   <= 1'b0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (enable)
                pre <= step ? '0 : pre + 1'b1;
            if (step)
                cnt <= cnt + 1'b1;
            pwm_out     <= enable & (cnt < duty);
            period_tick <= wrap;
            // accept and a full-register load are exclusive: accept needs an empty register
            if (accept) begin
                hold      <= sample_in;
                hold_full <= 1'b1;
            end
            if (wrap && hold_full) begin
                duty      <= sum[WIDTH-1:0];
                hold_full <= 1'b0;
            end
            if (wrap && !hold_full)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed checks of pwm_dac duty, handshake, gain, underrun and enable behaviour
module tb_pwm_dac;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       sample_valid = 1'b0;
    logic [1:0] gain = 2'd0;
    logic       clr_underrun = 1'b0;
    logic       sample_ready;
    logic       pwm_out;
    logic       period_tick;
    logic       underrun;
    logic       en4 = 1'b1;
    logic       ready4;
    logic       pwm4;
    logic       tick4;
    logic       under4;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    pwm_dac #(.PRESCALE(1), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .gain(gain),
        .clr_underrun(clr_underrun), .pwm_out(pwm_out), .period_tick(period_tick),
        .underrun(underrun)
    );

    pwm_dac #(.PRESCALE(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .sample_in(8'h00),
        .sample_valid(1'b0), .sample_ready(ready4), .gain(2'd0),
        .clr_underrun(1'b0), .pwm_out(pwm4), .period_tick(tick4),
        .underrun(under4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_tick && k < 3000);
        if (!period_tick)
            chk(tag, 0, 1);
    endtask

    // Called on the negedge showing period_tick; counts the following period's samples.
    task automatic run_period(input bit push, input logic [7:0] v, output int len, output int hi);
        len = 0;
        hi  = 0;
        if (push) begin
            sample_in    = v;
            sample_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            if (len == 0) begin
                if (push)
                    sample_valid = 1'b0;
                clr_underrun = 1'b0;
                chk("tick_width", period_tick, 0);
            end
            len++;
            hi += int'(pwm_out);
        end while (!period_tick && len < 3000);
        if (!period_tick)
            chk("period_timeout", len, 256);
    endtask

    task automatic run4(input int dis_at, output int len, output int hi);
        len = 0;
        hi  = 0;
        do begin
            @(negedge clk);
            len++;
            hi += int'(pwm4);
            if (len == dis_at) begin
                chk("pwm4_before_dis", pwm4, 1);
                en4 = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    len++;
                    hi += int'(pwm4);
                end
                chk("pwm4_disabled", pwm4, 0);
                en4 = 1'b1;
            end
        end while (!tick4 && len < 5000);
        if (!tick4)
            chk("period4_timeout", len, 1024);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        int hi;
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre_rst_pwm", pwm_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_tick", period_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick("first_tick");
        chk("first_underrun", underrun, 1);
        run_period(1'b1, 8'h80, len, hi);
        chk("rst_duty_hi", hi, 128);
        chk("rst_len", len, 256);

        clr_underrun = 1'b1;
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        run_period(1'b0, 8'h80, len, hi);
        chk("mid_hi_1", hi, 128);
        run_period(1'b0, 8'h80, len, hi);
        chk("mid_hi_2", hi, 128);
        chk("mid_len", len, 256);
        chk("mid_no_underrun", underrun, 0);

        run_period(1'b1, 8'h00, len, hi);
        chk("mid_hi_3", hi, 128);
        run_period(1'b1, 8'hFF, len, hi);
        chk("duty_zero", hi, 0);
        gain = 2'd2;
        run_period(1'b1, 8'hFF, len, hi);
        chk("duty_ff", hi, 255);
        chk("duty_ff_len", len, 256);
        run_period(1'b1, 8'h00, len, hi);
        chk("gain2_ff", hi, 159);
        gain = 2'd3;
        run_period(1'b1, 8'h80, len, hi);
        chk("gain2_00", hi, 96);
        gain = 2'd0;
        run_period(1'b1, 8'h40, len, hi);
        chk("gain3_80", hi, 128);
        chk("no_underrun", underrun, 0);
        run_period(1'b0, 8'h00, len, hi);
        chk("duty_40", hi, 64);
        chk("underrun_set", underrun, 1);
        run_period(1'b0, 8'h00, len, hi);
        chk("underrun_repeat", hi, 64);

        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("clr", underrun, 0);
        repeat (254) @(negedge clk);
        chk("clr_hold", underrun, 0);
        clr_underrun = 1'b1;
        @(negedge clk);
        chk("tick_align", period_tick, 1);
        chk("clr_set_wins", underrun, 1);
        clr_underrun = 1'b0;
        @(negedge clk);
        chk("sticky", underrun, 1);

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick4 && k < 3000);
        if (!tick4)
            chk("tick4_wait", 0, 1);
        run4(0, len, hi);
        chk("p4_len", len, 1024);
        chk("p4_hi", hi, 512);
        run4(100, len, hi);
        chk("p4_dis_len", len, 1034);
        chk("p4_dis_hi", hi, 512);
        chk("p4_underrun", under4, 1);
        chk("p4_ready", ready4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
